// File: rtl/spmv_row_sequencer_pkg.sv
// Shared types for the SpMV row sequencer: FSM state encoding and the
// result record that travels through the result FIFO.
package spmv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } seq_state_t;

    typedef struct packed {
        int data;
        int index;
        bit last;
    } row_result_t;

endpackage

// File: rtl/spmv_row_sequencer_if.sv
// Indexed result stream from the row sequencer to its downstream consumer.
interface spmv_row_sequencer_if;

    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [31:0] res_index;
    logic        res_last;

    modport master (
        output res_valid,
        output res_data,
        output res_index,
        output res_last,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_data,
        input  res_index,
        input  res_last,
        output res_ready
    );

endinterface

// File: rtl/spmv_row_sequencer_result_fifo.sv
// Circular result FIFO; a push is accepted on a full FIFO when a pop
// happens on the same edge.
module spmv_result_fifo
    import spmv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  row_result_t push_data,
    input  logic        pop,
    output row_result_t head,
    output logic        full,
    output logic        empty,
    output logic        last_entry
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    row_result_t   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign last_entry = (count == CW'(1));
    assign do_pop     = pop && !empty;
    assign do_push    = push && (!full || do_pop);
    assign head       = mem[rd_ptr];

    // Storage is left unreset; stale entries are never visible because
    // the consumer side gates the head with the empty flag.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/spmv_row_sequencer.sv
// Walks rowIndex over n rows of the combinational CSR multiplier, lets each
// row settle SETTLE cycles, and streams indexed results through a FIFO.
module spmv_row_sequencer
    import spmv_pkg::*;
#(
    parameter int n      = 0,
    parameter int SETTLE = 1,
    parameter int DEPTH  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic signed [31:0]   rowIndex,
    output logic                 mult_rst,
    input  logic signed [31:0]   rowOutput,
    spmv_row_sequencer_if.master res
);

    localparam logic [31:0]        SETTLE_LAST = 32'(SETTLE - 1);
    localparam logic signed [31:0] LAST_ROW    = 32'(n - 1);

    seq_state_t  state;
    seq_state_t  state_nx;
    logic [31:0] settle_cnt;
    logic        settled;
    logic        is_last;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic        last_entry;
    row_result_t push_data;
    row_result_t head;

    // Row presented at edge T is captured at edge T+SETTLE, i.e. on the
    // edge where the counter would step past SETTLE-1.
    assign settled   = (state == RUN) && (settle_cnt == SETTLE_LAST);
    assign is_last   = (rowIndex == LAST_ROW);
    assign pop       = !empty && res.res_ready;
    assign push      = settled && (!full || pop);
    assign push_data = '{data: rowOutput, index: rowIndex, last: is_last};

    spmv_result_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .last_entry(last_entry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (n == 0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (push && is_last) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && last_entry) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        mult_rst = 1'b1;
        case (state)
            RUN: begin
                busy     = 1'b1;
                mult_rst = 1'b0;
            end
            DRAIN: begin
                busy = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // A full FIFO freezes both rowIndex and the settle counter, so the
    // capture simply retries on each following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rowIndex   <= '0;
            settle_cnt <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                rowIndex   <= '0;
                settle_cnt <= '0;
            end
        end else if (state == RUN) begin
            if (!settled) begin
                settle_cnt <= settle_cnt + 32'd1;
            end else if (push && !is_last) begin
                rowIndex   <= rowIndex + 32'sd1;
                settle_cnt <= '0;
            end
        end
    end

    assign res.res_valid = !empty;
    assign res.res_data  = empty ? '0 : head.data;
    assign res.res_index = empty ? '0 : head.index;
    assign res.res_last  = empty ? 1'b0 : head.last;

endmodule

// File: tb/tb_spmv_row_sequencer.sv
// Directed bench for spmv_row_sequencer with a result scoreboard and a
// combinational multiplier model (10*row+7) per DUT.
module tb_spmv_row_sequencer;
    import spmv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start;
    logic ready;
    logic neg_mode;
    int   sel;
    int   total = 0;
    int   bad   = 0;

    row_result_t sb[$];

    logic st_a, st_b, st_c;
    logic busy_a, busy_b, busy_c;
    logic done_a, done_b, done_c;
    logic mrst_a, mrst_b, mrst_c;
    logic signed [31:0] row_a, row_b, row_c;
    logic signed [31:0] out_a, out_b, out_c;

    spmv_row_sequencer_if ia ();
    spmv_row_sequencer_if ib ();
    spmv_row_sequencer_if ic ();

    assign st_a = start && (sel == 0);
    assign st_b = start && (sel == 1);
    assign st_c = start && (sel == 2);
    assign ia.res_ready = ready && (sel == 0);
    assign ib.res_ready = ready && (sel == 1);
    assign ic.res_ready = ready && (sel == 2);

    spmv_row_sequencer #(.n(4), .SETTLE(1), .DEPTH(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(st_a), .busy(busy_a), .done(done_a),
        .rowIndex(row_a), .mult_rst(mrst_a), .rowOutput(out_a), .res(ia)
    );
    spmv_row_sequencer #(.n(4), .SETTLE(3), .DEPTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(st_b), .busy(busy_b), .done(done_b),
        .rowIndex(row_b), .mult_rst(mrst_b), .rowOutput(out_b), .res(ib)
    );
    spmv_row_sequencer #(.n(0), .SETTLE(1), .DEPTH(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(st_c), .busy(busy_c), .done(done_c),
        .rowIndex(row_c), .mult_rst(mrst_c), .rowOutput(out_c), .res(ic)
    );

    // Multiplier models; B returns garbage for two cycles after each new row.
    int                 age_b      = 100;
    logic signed [31:0] prev_row_b = '0;
    logic               prev_mrst_b = 1'b1;

    always @(negedge clk) begin
        if (row_b != prev_row_b || (prev_mrst_b && !mrst_b)) begin
            age_b <= 0;
        end else if (age_b < 100) begin
            age_b <= age_b + 1;
        end
        prev_row_b  <= row_b;
        prev_mrst_b <= mrst_b;
    end

    assign out_a = (neg_mode && row_a == 32'sd1) ? -32'sd5 : row_a * 32'sd10 + 32'sd7;
    assign out_b = (age_b < 2) ? 32'sh0000DEAD : row_b * 32'sd10 + 32'sd7;
    assign out_c = row_c * 32'sd10 + 32'sd7;

    logic        m_valid, m_last, m_busy, m_done, m_mrst;
    logic [31:0] m_data, m_index, m_row;

    always_comb begin
        case (sel)
            1: begin
                m_valid = ib.res_valid; m_data = ib.res_data; m_index = ib.res_index;
                m_last = ib.res_last; m_busy = busy_b; m_done = done_b;
                m_row = row_b; m_mrst = mrst_b;
            end
            2: begin
                m_valid = ic.res_valid; m_data = ic.res_data; m_index = ic.res_index;
                m_last = ic.res_last; m_busy = busy_c; m_done = done_c;
                m_row = row_c; m_mrst = mrst_c;
            end
            default: begin
                m_valid = ia.res_valid; m_data = ia.res_data; m_index = ia.res_index;
                m_last = ia.res_last; m_busy = busy_a; m_done = done_a;
                m_row = row_a; m_mrst = mrst_a;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input bit negative_row1);
        row_result_t e;
        for (int i = 0; i < 4; i++) begin
            e.data  = (negative_row1 && i == 1) ? -5 : 10 * i + 7;
            e.index = i;
            e.last  = (i == 3);
            sb.push_back(e);
        end
    endtask

    // Called at a falling edge: drive inputs, score a pop that the next
    // rising edge will perform, then advance to the next falling edge.
    task automatic step(input logic st, input logic rdy, output bit popped);
        row_result_t e;
        start  = st;
        ready  = rdy;
        popped = 1'b0;
        if (m_valid && rdy) begin
            popped = 1'b1;
            if (sb.size() == 0) begin
                chk("result with empty scoreboard", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("res_data", m_data, 32'(e.data));
                chk("res_index", m_index, 32'(e.index));
                chk("res_last", {31'd0, m_last}, {31'd0, e.last});
            end
        end
        @(negedge clk);
    endtask

    task automatic start_run(input logic rdy, input bit has_rows);
        bit p;
        step(1'b1, rdy, p);
        chk("busy after start", {31'd0, m_busy}, 32'd1);
        if (has_rows) begin
            chk("rowIndex after start", m_row, 32'd0);
            chk("mult_rst after start", {31'd0, m_mrst}, 32'd0);
            chk("valid after start", {31'd0, m_valid}, 32'd0);
        end
    endtask

    task automatic run(input int hold, input int gap, input int poke);
        int last_pop = -1;
        bit fin = 1'b0;
        bit p;
        for (int k = 0; k < 300 && !fin; k++) begin
            if (hold > 0 && k == hold) begin
                chk("held rowIndex", m_row, 32'd2);
                chk("held head index", m_index, 32'd0);
                chk("held valid", {31'd0, m_valid}, 32'd1);
            end
            if (m_done) begin
                chk("done after final pop", 32'(k), 32'(last_pop + 1));
                chk("busy with done", {31'd0, m_busy}, 32'd1);
                chk("scoreboard drained", 32'(sb.size()), 32'd0);
                step(1'b0, 1'b1, p);
                chk("done single pulse", {31'd0, m_done}, 32'd0);
                chk("busy dropped", {31'd0, m_busy}, 32'd0);
                chk("mult_rst idle", {31'd0, m_mrst}, 32'd1);
                fin = 1'b1;
            end else begin
                step(k == poke, k >= hold, p);
                if (p) begin
                    if (gap > 0 && last_pop >= 0) begin
                        chk("pop spacing", 32'(k - last_pop), 32'(gap));
                    end
                    last_pop = k;
                end
            end
        end
        chk("run completes", {31'd0, fin}, 32'd1);
    endtask

    task automatic chk_reset();
        chk("reset busy", {31'd0, m_busy}, 32'd0);
        chk("reset done", {31'd0, m_done}, 32'd0);
        chk("reset rowIndex", m_row, 32'd0);
        chk("reset mult_rst", {31'd0, m_mrst}, 32'd1);
        chk("reset res_valid", {31'd0, m_valid}, 32'd0);
        chk("reset res_data", m_data, 32'd0);
        chk("reset res_index", m_index, 32'd0);
        chk("reset res_last", {31'd0, m_last}, 32'd0);
    endtask

    initial begin
        bit p;
        int pops;
        rst_n    = 1'b0;
        start    = 1'b0;
        ready    = 1'b0;
        neg_mode = 1'b0;
        sel      = 0;
        repeat (2) @(negedge clk);
        chk_reset();
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back streaming at one result per cycle.
        push_exp(1'b0);
        start_run(1'b1, 1'b1);
        run(0, 1, -1);

        // Backpressure with a two-entry FIFO.
        push_exp(1'b0);
        start_run(1'b0, 1'b1);
        run(10, 0, -1);

        // Start pulse mid-run must be ignored.
        push_exp(1'b0);
        start_run(1'b1, 1'b1);
        run(0, 1, 2);

        // Negative result passes through unchanged.
        neg_mode = 1'b1;
        push_exp(1'b1);
        start_run(1'b1, 1'b1);
        run(0, 1, -1);
        neg_mode = 1'b0;

        // SETTLE=3 with garbage on rowOutput during settling.
        sel = 1;
        push_exp(1'b0);
        start_run(1'b1, 1'b1);
        run(0, 3, -1);

        // Zero-row run.
        sel = 2;
        start_run(1'b1, 1'b0);
        chk("n0 done immediately", {31'd0, m_done}, 32'd1);
        run(0, 0, -1);

        // Asynchronous reset after two pops, then a clean restart.
        sel = 0;
        push_exp(1'b0);
        start_run(1'b1, 1'b1);
        pops = 0;
        for (int k = 0; k < 50 && pops < 2; k++) begin
            step(1'b0, 1'b1, p);
            if (p) pops++;
        end
        chk("pops before reset", 32'(pops), 32'd2);
        #2 rst_n = 1'b0;
        #1 chk_reset();
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_exp(1'b0);
        start_run(1'b1, 1'b1);
        run(0, 1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
